// File: rtl/bcd_serial_adder.sv
// rtl/bcd_serial_adder.sv - digit-serial packed-BCD adder/subtractor, one 4-bit slice per cycle
module bcd_serial_adder #(
  parameter int DIGITS = 4,
  parameter int SUB_EN = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                mode,
  input  logic [4*DIGITS-1:0] a_in,
  input  logic [4*DIGITS-1:0] b_in,
  input  logic                cin,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] sum,
  output logic                cout,
  output logic                err
);

  localparam int W  = 4 * DIGITS;
  localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          mode_q, mode_d, carry_q, carry_d, bad_q, bad_d;
  logic          cout_q, cout_d, err_q, err_d;

  logic          mode_eff;
  logic [3:0]    a_dig, b_dig, b_eff, dig;
  logic [4:0]    t;
  logic          carry_out, dig_bad, last, op_bad;
  logic [W-1:0]  a_next;

  assign mode_eff = (SUB_EN != 0) && mode;

  // Digit slice; a_q doubles as the result register, results shift in from the top.
  always_comb begin
    a_dig     = a_q[3:0];
    b_dig     = b_q[3:0];
    b_eff     = mode_q ? (4'd9 - b_dig) : b_dig;
    t         = {1'b0, a_dig} + {1'b0, b_eff} + {4'b0000, carry_q};
    carry_out = (t > 5'd9);
    dig       = carry_out ? (t[3:0] + 4'd6) : t[3:0];
    dig_bad   = (a_dig > 4'd9) || (b_dig > 4'd9);
    op_bad    = bad_q || dig_bad;
    last      = (cnt_q == CW'(DIGITS - 1));
    a_next    = (a_q >> 4) | (W'(dig) << (W - 4));
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    carry_d = carry_q;
    bad_d   = bad_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          a_d     = a_in;
          b_d     = b_in;
          mode_d  = mode_eff;
          carry_d = mode_eff ? ~cin : cin;
          cnt_d   = '0;
          bad_d   = 1'b0;
        end
      end
      S_RUN: begin
        a_d     = a_next;
        b_d     = b_q >> 4;
        carry_d = carry_out;
        bad_d   = op_bad;
        cnt_d   = cnt_q + CW'(1);
        if (last) begin
          state_d = S_DONE;
          err_d   = op_bad;
          if (op_bad) begin
            cout_d = 1'b0;
          end else begin
            sum_d  = a_next;
            cout_d = mode_q ? ~carry_out : carry_out;
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
      carry_q <= 1'b0;
      bad_q   <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      carry_q <= carry_d;
      bad_q   <= bad_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      err_q   <= err_d;
    end
  end

  assign busy = (state_q != S_IDLE);
  assign done = (state_q == S_DONE);
  assign sum  = sum_q;
  assign cout = cout_q;
  assign err  = err_q;

endmodule

// File: tb/tb_bcd_serial_adder.sv
// tb/tb_bcd_serial_adder.sv - directed self-checking bench for bcd_serial_adder (DIGITS=4)
module tb_bcd_serial_adder;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        mode;
  logic [15:0] a_in;
  logic [15:0] b_in;
  logic        cin;
  logic        busy;
  logic        done;
  logic [15:0] sum;
  logic        cout;
  logic        err;

  int checks   = 0;
  int failures = 0;

  bcd_serial_adder #(.DIGITS(4), .SUB_EN(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .mode  (mode),
    .a_in  (a_in),
    .b_in  (b_in),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .err   (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Cycle 1 is the accepting edge itself; done is due in cycle 5.
  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic m, input logic ci, input logic [15:0] es,
                        input logic ec, input logic ee);
    int k;
    a_in  = a;
    b_in  = b;
    mode  = m;
    cin   = ci;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
    k = 1;
    while (!done && k < 20) begin
      tick();
      k++;
    end
    chk({tag, "_latency"}, k, 32'd5);
    chk({tag, "_sum"}, {16'd0, sum}, {16'd0, es});
    chk({tag, "_cout"}, {31'd0, cout}, {31'd0, ec});
    chk({tag, "_err"}, {31'd0, err}, {31'd0, ee});
    tick();
    chk({tag, "_done_pulse"}, {30'd0, done, busy}, 32'd0);
  endtask

  initial begin
    logic seen_done;
    int   n_done;
    rst_n = 1'b0;
    start = 1'b0;
    mode  = 1'b0;
    a_in  = '0;
    b_in  = '0;
    cin   = 1'b0;
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_sum",  {16'd0, sum},  32'd0);
    chk("rst_cout", {31'd0, cout}, 32'd0);
    chk("rst_err",  {31'd0, err},  32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    run_op("add_1234_5678", 16'h1234, 16'h5678, 1'b0, 1'b0, 16'h6912, 1'b0, 1'b0);
    run_op("err_12A4",      16'h12A4, 16'h0000, 1'b0, 1'b0, 16'h6912, 1'b0, 1'b1);
    run_op("add_4321_1111", 16'h4321, 16'h1111, 1'b0, 1'b0, 16'h5432, 1'b0, 1'b0);
    run_op("add_9999_0001", 16'h9999, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_op("add_0_0_cin",   16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0001, 1'b0, 1'b0);
    run_op("sub_0100_0001", 16'h0100, 16'h0001, 1'b1, 1'b0, 16'h0099, 1'b0, 1'b0);
    run_op("sub_0000_0001", 16'h0000, 16'h0001, 1'b1, 1'b0, 16'h9999, 1'b1, 1'b0);
    run_op("err_sub_B000",  16'h0000, 16'hB000, 1'b1, 1'b0, 16'h9999, 1'b0, 1'b1);
    run_op("sub_5_3_bin",   16'h0005, 16'h0003, 1'b1, 1'b1, 16'h0001, 1'b0, 1'b0);

    a_in  = 16'h5555;
    b_in  = 16'h1111;
    mode  = 1'b0;
    cin   = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_done", {31'd0, done}, 32'd0);
    chk("midrst_sum",  {16'd0, sum},  32'd0);
    chk("midrst_cout", {31'd0, cout}, 32'd0);
    chk("midrst_err",  {31'd0, err},  32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    seen_done = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      seen_done = seen_done | done;
    end
    chk("midrst_no_done", {31'd0, seen_done}, 32'd0);
    run_op("post_rst_add", 16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0);

    a_in   = 16'h1111;
    b_in   = 16'h2222;
    mode   = 1'b0;
    cin    = 1'b0;
    start  = 1'b1;
    n_done = 0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (done) n_done++;
      chk($sformatf("tput_done_c%0d", k), {31'd0, done}, {31'd0, (k == 5 || k == 11)});
      chk($sformatf("tput_busy_c%0d", k), {31'd0, busy}, {31'd0, !(k == 6 || k == 12)});
      if (k == 5)  chk("tput_sum1", {16'd0, sum}, 32'h3333);
      if (k == 11) chk("tput_sum2", {16'd0, sum}, 32'h3456);
      if (k == 2) begin
        a_in = 16'h9999;
        b_in = 16'h9999;
      end
      if (k == 5) begin
        a_in = 16'h2345;
        b_in = 16'h1111;
      end
      if (k == 8) begin
        a_in = 16'h0000;
        b_in = 16'h0000;
      end
      if (k == 12) start = 1'b0;
    end
    chk("tput_ndone", n_done, 32'd2);
    tick();
    chk("tput_idle", {31'd0, busy}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
